// File: rtl/fir_stream_ctrl.sv
// Stream sequencer and coefficient front-end for a 3-tap FIR datapath.
// Define FIR_CTRL_SAT_EN to clamp overflowed output samples to +/-16000.
module fir_stream_ctrl #(
  parameter int CNT_W     = 8,
  parameter int DRAIN_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  input  logic             cfg_commit,
  input  logic             start,
  input  logic             stop,
  input  logic             ovf_clr,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             filt_rst,
  output logic [7:0]       filt_data_in,
  output logic [7:0]       filt_coeff0,
  output logic [7:0]       filt_coeff1,
  output logic [7:0]       filt_coeff2,
  input  logic [15:0]      filt_data_out,
  input  logic             filt_ovf,
  output logic             m_valid,
  output logic [15:0]      m_data,
  output logic             m_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] ovf_count,
  output logic             ovf_sticky
);

  localparam int DW = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN + 1) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   drain_cnt;
  logic [7:0]      shadow [3];
  logic [7:0]      coeff  [3];
  logic            commit_pending;
  logic            tv1;
  logic [15:0]     data_q;
  logic            accept;
  logic            tv0;
  logic            drain_last;
  logic            apply_commit;

  assign accept       = (state == RUN) && s_valid;
  assign tv0          = accept || (state == DRAIN);
  assign drain_last   = (state == DRAIN) && (drain_cnt == DW'(DRAIN_LEN - 1));
  assign apply_commit = ((state == IDLE) && cfg_commit) ||
                        (drain_last && (commit_pending || cfg_commit));

  assign s_ready      = (state == RUN);
  assign filt_rst     = rst || (state == CLEAR);
  assign filt_data_in = accept ? s_data : 8'd0;
  assign filt_coeff0  = coeff[0];
  assign filt_coeff1  = coeff[1];
  assign filt_coeff2  = coeff[2];
  assign busy         = (state != IDLE) || tv1 || m_valid;

  // The filter reports overflow one cycle late, which lines up with the registered sample.
  assign m_ovf = m_valid && filt_ovf;

`ifdef FIR_CTRL_SAT_EN
  assign m_data = !m_ovf ? data_q :
                  ($signed(data_q) > 16'sd0) ? 16'h3E80 : 16'hC180;
`else
  assign m_data = data_q;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR; else state_next = IDLE;
      CLEAR:   state_next = RUN;
      RUN:     if (stop) state_next = DRAIN; else state_next = RUN;
      DRAIN:   if (drain_last) state_next = IDLE; else state_next = DRAIN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
      else                drain_cnt <= '0;
    end
  end

  // Commit copies the shadow value as it stood before any same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        shadow[i] <= 8'd0;
        coeff[i]  <= 8'd0;
      end
      commit_pending <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    shadow[0] <= cfg_wdata;
          2'd1:    shadow[1] <= cfg_wdata;
          2'd2:    shadow[2] <= cfg_wdata;
          default: ;
        endcase
      end
      if (apply_commit) begin
        coeff          <= shadow;
        commit_pending <= 1'b0;
      end else if (cfg_commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv1     <= 1'b0;
      m_valid <= 1'b0;
      data_q  <= 16'd0;
    end else if (state == CLEAR) begin
      tv1     <= 1'b0;
      m_valid <= 1'b0;
      data_q  <= 16'd0;
    end else begin
      tv1     <= tv0;
      m_valid <= tv1;
      data_q  <= filt_data_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (ovf_clr) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (m_valid && m_ovf) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != {CNT_W{1'b1}})
        ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench for fir_stream_ctrl with a 3-tap FIR stand-in and a burst-level model.
// Build with FIR_CTRL_SAT_EN defined to exercise output clamping.
module tb_fir_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0, cfg_commit = 1'b0, start = 1'b0, stop = 1'b0, ovf_clr = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [7:0]  cfg_wdata = 8'd0, s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready, filt_rst, m_valid, m_ovf, busy, ovf_sticky, filt_ovf;
  logic [7:0]  filt_data_in, filt_coeff0, filt_coeff1, filt_coeff2, ovf_count;
  logic [15:0] filt_data_out, m_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fir_stream_ctrl #(.CNT_W(8), .DRAIN_LEN(2)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .start(start), .stop(stop), .ovf_clr(ovf_clr),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .filt_rst(filt_rst),
    .filt_data_in(filt_data_in), .filt_coeff0(filt_coeff0), .filt_coeff1(filt_coeff1),
    .filt_coeff2(filt_coeff2), .filt_data_out(filt_data_out), .filt_ovf(filt_ovf),
    .m_valid(m_valid), .m_data(m_data), .m_ovf(m_ovf), .busy(busy),
    .ovf_count(ovf_count), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  function automatic bit is_ovf(int y);
    return (y > 16000) || (y < -16000);
  endfunction

  function automatic int mul8(logic [7:0] a, logic [7:0] b);
    return int'($signed(a)) * int'($signed(b));
  endfunction

  // FIR stand-in: registered output, overflow flag describes the previous output.
  logic [31:0] f_sum = 32'd0;
  logic [7:0]  f_d1 = 8'd0, f_d2 = 8'd0;
  logic        f_ovf = 1'b0;
  assign filt_data_out = f_sum[15:0];
  assign filt_ovf      = f_ovf;

  always @(posedge clk) begin
    if (filt_rst) begin
      f_sum <= 32'd0; f_d1 <= 8'd0; f_d2 <= 8'd0; f_ovf <= 1'b0;
    end else begin
      f_sum <= 32'(mul8(filt_coeff0, filt_data_in) + mul8(filt_coeff1, f_d1) + mul8(filt_coeff2, f_d2));
      f_d1  <= filt_data_in;
      f_d2  <= f_d1;
      f_ovf <= is_ovf(int'($signed(f_sum)));
    end
  end

  // Burst-level model: sample history since CLEAR convolved with active coefficients.
  typedef struct { bit v; int y; } ent_t;
  ent_t e_p1 = '{1'b0, 0};
  ent_t e_m  = '{1'b0, 0};
  int   st = 0, dc = 0, cnt = 0;
  int   sh[3] = '{0, 0, 0};
  int   act[3] = '{0, 0, 0};
  bit   pend = 1'b0, stk = 1'b0;
  int   xs[$];

  function automatic int conv();
    int y = 0;
    for (int k = 0; k < 3; k++)
      if (xs.size() > k) y += act[k] * xs[xs.size() - 1 - k];
    return y;
  endfunction

  function automatic logic [15:0] exp_data(int y);
    logic [31:0] w = 32'(y);
    logic [15:0] r = w[15:0];
`ifdef FIR_CTRL_SAT_EN
    if (is_ovf(y)) r = ($signed(r) > 16'sd0) ? 16'd16000 : 16'hC180;
`endif
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        st = 0; dc = 0; cnt = 0; pend = 1'b0; stk = 1'b0; xs.delete();
        e_p1 = '{1'b0, 0}; e_m = '{1'b0, 0};
        for (int i = 0; i < 3; i++) begin sh[i] = 0; act[i] = 0; end
      end else begin
        int   x;
        bit   tag, last, apply;
        ent_t e;
        x    = (st == 2 && s_valid) ? int'($signed(s_data)) : 0;
        tag  = (st == 2 && s_valid) || st == 3;
        last = (st == 3) && (dc == 1);
        if (ovf_clr) begin cnt = 0; stk = 1'b0; end
        else if (e_m.v && is_ovf(e_m.y)) begin stk = 1'b1; if (cnt < 255) cnt++; end
        if (st == 1) begin
          xs.delete(); e_p1 = '{1'b0, 0}; e_m = '{1'b0, 0};
        end else begin
          xs.push_back(x);
          e.v = tag; e.y = conv();
          e_m = e_p1; e_p1 = e;
        end
        apply = (st == 0 && cfg_commit) || (last && (pend || cfg_commit));
        if (apply) begin act = sh; pend = 1'b0; end
        else if (cfg_commit) pend = 1'b1;
        if (cfg_we && cfg_addr != 2'd3) sh[cfg_addr] = int'($signed(cfg_wdata));
        case (st)
          0: if (start) st = 1;
          1: st = 2;
          2: if (stop) begin st = 3; dc = 0; end
          3: if (last) st = 0; else dc++;
          default: st = 0;
        endcase
      end
    end
  end

  task automatic chk(string name, logic [31:0] actual, logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  logic [15:0] cap_data[$];
  logic        cap_ovf[$];
  int          cap_cyc[$];

  // Per-cycle comparison against the model, plus capture of delivered samples.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      chk("m_valid", m_valid, e_m.v);
      if (e_m.v) begin
        chk("m_data", m_data, exp_data(e_m.y));
        chk("m_ovf", m_ovf, is_ovf(e_m.y));
      end
      chk("s_ready", s_ready, st == 2);
      chk("filt_rst", filt_rst, rst || st == 1);
      chk("busy", busy, st != 0 || e_p1.v || e_m.v);
      chk("ovf_count", ovf_count, cnt);
      chk("ovf_sticky", ovf_sticky, stk);
      chk("coeff0", filt_coeff0, act[0] & 255);
      chk("coeff1", filt_coeff1, act[1] & 255);
      chk("coeff2", filt_coeff2, act[2] & 255);
      if (m_valid) begin
        cap_data.push_back(m_data); cap_ovf.push_back(m_ovf); cap_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(logic sv, logic [7:0] sd, logic st_i, logic sp, logic clr = 1'b0);
    @(negedge clk);
    s_valid = sv; s_data = sd; start = st_i; stop = sp; ovf_clr = clr;
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic cfgw(logic [1:0] a, logic [7:0] v);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = v;
  endtask

  task automatic commit();
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    cfg_commit = 1'b1;
  endtask

  task automatic setc(logic [7:0] c0, logic [7:0] c1, logic [7:0] c2);
    cfgw(2'd0, c0); cfgw(2'd1, c1); cfgw(2'd2, c2); commit(); idle(1);
  endtask

  task automatic begin_burst();
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic clear_cap();
    cap_data.delete(); cap_ovf.delete(); cap_cyc.delete();
  endtask

  logic [15:0] exp1[5] = '{16'd10, 16'd40, 16'd100, 16'd120, 16'd90};
  logic [15:0] exp3[4] = '{16'd5, 16'd7, 16'd7, 16'd0};
  logic [15:0] exp2;
  int          t_acc;

  initial begin
    idle(2);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_filt_rst", filt_rst, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_coeff0", filt_coeff0, 8'd0);
    @(negedge clk); rst = 1'b0;
    idle(2);

    // Burst of 10,20,30 through coefficients 1,2,3
    setc(8'd1, 8'd2, 8'd3);
    begin_burst();
    clear_cap();
    drive(1'b1, 8'd10, 1'b0, 1'b0);
    t_acc = cyc;
    drive(1'b1, 8'd20, 1'b0, 1'b0);
    drive(1'b1, 8'd30, 1'b0, 1'b1);
    idle(8);
    chk("t1_count", cap_data.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < cap_data.size()) begin
        chk("t1_data", cap_data[i], exp1[i]);
        chk("t1_ovf", cap_ovf[i], 1'b0);
      end
    if (cap_cyc.size() > 0) chk("t1_latency", cap_cyc[0] - t_acc, 2);
    chk("t1_busy", busy, 1'b0);

    // Single full-scale sample: three overflowing outputs
    setc(8'd127, 8'd127, 8'd127);
    begin_burst();
    clear_cap();
    drive(1'b1, 8'd127, 1'b0, 1'b1);
    idle(8);
`ifdef FIR_CTRL_SAT_EN
    exp2 = 16'd16000;
`else
    exp2 = 16'd16129;
`endif
    chk("t2_count", cap_data.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < cap_data.size()) begin
        chk("t2_data", cap_data[i], exp2);
        chk("t2_ovf", cap_ovf[i], 1'b1);
      end
    chk("t2_ovf_count", ovf_count, 8'd3);
    chk("t2_sticky", ovf_sticky, 1'b1);

    // Bubble in the input stream is zero-stuffed but never delivered
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t3_clr", ovf_count, 8'd0);
    setc(8'd1, 8'd1, 8'd0);
    begin_burst();
    clear_cap();
    drive(1'b1, 8'd5, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 8'd7, 1'b0, 1'b1);
    idle(8);
    chk("t3_count", cap_data.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < cap_data.size()) chk("t3_data", cap_data[i], exp3[i]);

    // Commit during RUN waits for the end of DRAIN
    begin_burst();
    cfgw(2'd0, 8'd4);
    commit();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    idle(1);
    chk("t4_drain1_c0", filt_coeff0, 8'd1);
    idle(1);
    chk("t4_drain2_c0", filt_coeff0, 8'd1);
    idle(1);
    chk("t4_idle_c0", filt_coeff0, 8'd4);
    idle(4);
    begin_burst();
    clear_cap();
    drive(1'b1, 8'd3, 1'b0, 1'b1);
    idle(8);
    if (cap_data.size() > 0) chk("t4_data", cap_data[0], 16'd12);
    else chk("t4_count", cap_data.size(), 3);

    // Counter saturation, then clear against a same-cycle increment
    setc(8'd127, 8'd127, 8'd127);
    begin_burst();
    repeat (262) drive(1'b1, 8'd127, 1'b0, 1'b0);
    chk("t5_sat", ovf_count, 8'd255);
    drive(1'b1, 8'd127, 1'b0, 1'b0);
    chk("t5_still_sat", ovf_count, 8'd255);
    drive(1'b1, 8'd127, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd127, 1'b0, 1'b0);
    chk("t5_clr_wins", ovf_count, 8'd0);
    chk("t5_clr_sticky", ovf_sticky, 1'b0);
    drive(1'b1, 8'd127, 1'b0, 1'b1);
    idle(6);

    // Reset in the middle of a burst drops everything in flight
    begin_burst();
    drive(1'b1, 8'd1, 1'b0, 1'b0);
    drive(1'b1, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; s_data = 8'd0;
    clear_cap();
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    chk("t6_no_valid", cap_data.size(), 0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", s_ready, 1'b0);
    chk("t6_coeff0", filt_coeff0, 8'd0);
    chk("t6_coeff2", filt_coeff2, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
